// File: rtl/pla_resp_capture.sv
// Captures PLA response vectors: buffers them in a small FIFO toward the
// downstream comparator and folds every accepted vector into a MISR signature.
module pla_resp_capture #(
  parameter int unsigned OUT_W      = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  parameter logic [OUT_W-1:0] MISR_POLY = 24'h00001B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [OUT_W-1:0] signature,
  output logic             sig_valid,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty;
  logic             in_beat, out_beat, start_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W-1:0] sig_next;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid = !fifo_empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign in_beat   = in_valid && in_ready;
  assign out_beat  = out_valid && out_ready;
  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign cnt_inc   = vec_count + 1'b1;
  assign sig_next  = {signature[OUT_W-2:0], 1'b0}
                   ^ (signature[OUT_W-1] ? MISR_POLY : '0)
                   ^ in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (num_vec == '0) ? DONE : RUN;
      end
      RUN: begin
        if (in_beat && (cnt_inc == target)) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == RUN) && !fifo_full;
    busy      = (state_q == RUN) || (state_q == DRAIN);
    sig_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target    <= '0;
      signature <= '0;
      vec_count <= '0;
    end else if (start_ok) begin
      target    <= num_vec;
      signature <= '0;
      vec_count <= '0;
    end else if (in_beat) begin
      signature <= sig_next;
      vec_count <= cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (in_beat) begin
        mem[wr_ptr[AW-1:0]] <= in_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (out_beat) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_pla_resp_capture.sv
// Directed bench for pla_resp_capture with hand-computed expectations.
module tb_pla_resp_capture;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [15:0] num_vec;
  logic [23:0] in_data;
  logic        in_ready, out_valid, sig_valid, busy;
  logic [23:0] out_data, signature;
  logic [15:0] vec_count;

  int total = 0;
  int bad   = 0;

  pla_resp_capture dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .signature(signature), .sig_valid(sig_valid), .vec_count(vec_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_vec = n;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [23:0] d);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !sig_valid; i++) step();
    check("done_reached", {31'd0, sig_valid}, 32'd1);
  endtask

  initial begin
    logic       seen_ready;
    int         sent, got;
    logic       beat;

    rst = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_data",  {8'd0, out_data},   32'd0);
    check("rst_signature", {8'd0, signature},  32'd0);
    check("rst_vec_count", {16'd0, vec_count}, 32'd0);

    // Two back-to-back vectors with downstream always ready
    out_ready = 1'b1;
    do_start(16'd2);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_busy",     {31'd0, busy},     32'd1);
    in_valid = 1'b1; in_data = 24'h000001;
    step();
    check("t1_sig1",   {8'd0, signature}, 32'h000001);
    check("t1_ovalid", {31'd0, out_valid}, 32'd1);
    check("t1_odata1", {8'd0, out_data},  32'h000001);
    in_data = 24'h000002;
    step();
    in_valid = 1'b0;
    check("t1_sig2",      {8'd0, signature}, 32'h000000);
    check("t1_odata2",    {8'd0, out_data},  32'h000002);
    check("t1_cnt",       {16'd0, vec_count}, 32'd2);
    check("t1_ready_off", {31'd0, in_ready},  32'd0);
    check("t1_sv_early",  {31'd0, sig_valid}, 32'd0);
    wait_done();
    check("t1_sig_final", {8'd0, signature}, 32'h000000);
    check("t1_cnt_final", {16'd0, vec_count}, 32'd2);
    check("t1_empty",     {31'd0, out_valid}, 32'd0);

    // MISR restart and feedback polynomial
    do_start(16'd1);
    send(24'h800000);
    wait_done();
    check("t2_sig_a", {8'd0, signature}, 32'h800000);
    do_start(16'd1);
    check("t2_sig_clr", {8'd0, signature}, 32'h000000);
    check("t2_cnt_clr", {16'd0, vec_count}, 32'd0);
    send(24'h000000);
    wait_done();
    check("t2_sig_b", {8'd0, signature}, 32'h000000);
    do_start(16'd2);
    send(24'h800000);
    send(24'h000000);
    wait_done();
    check("t2_sig_poly", {8'd0, signature}, 32'h00001B);

    // Back-pressure: FIFO fills after four beats, then drains in order
    out_ready = 1'b0;
    do_start(16'd6);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 24'h0000A0 + 24'(i);
      check("t3_fill_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_data = 24'h0000A4;
    check("t3_full_ready", {31'd0, in_ready}, 32'd0);
    step(); step();
    check("t3_cnt_hold",  {16'd0, vec_count}, 32'd4);
    check("t3_head_hold", {8'd0, out_data},  32'h0000A0);
    check("t3_ovalid",    {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    sent = 4; got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (out_valid) begin
        check("t3_order", {8'd0, out_data}, 32'h0000A0 + 32'(got));
        got++;
      end
      beat = in_valid && in_ready;
      step();
      if (beat) begin
        sent++;
        if (sent < 6) in_data = 24'h0000A0 + 24'(sent);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("t3_got", 32'(got), 32'd6);
    check("t3_sent", 32'(sent), 32'd6);
    wait_done();
    check("t3_cnt", {16'd0, vec_count}, 32'd6);
    check("t3_no_extra", {31'd0, out_valid}, 32'd0);

    // Zero-length run goes straight to DONE
    do_start(16'd0);
    check("t4_sig_valid", {31'd0, sig_valid}, 32'd1);
    check("t4_sig",       {8'd0, signature},  32'd0);
    check("t4_busy",      {31'd0, busy},      32'd0);
    seen_ready = in_ready;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_ready = seen_ready | in_ready;
    end
    check("t4_no_ready", {31'd0, seen_ready}, 32'd0);

    // Reset mid-run with three entries buffered
    out_ready = 1'b0;
    do_start(16'd5);
    send(24'h111111);
    send(24'h222222);
    send(24'h333333);
    check("t5_cnt_pre",    {16'd0, vec_count}, 32'd3);
    check("t5_ovalid_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ovalid",   {31'd0, out_valid}, 32'd0);
    check("t5_busy",     {31'd0, busy},      32'd0);
    check("t5_sig",      {8'd0, signature},  32'd0);
    check("t5_cnt",      {16'd0, vec_count}, 32'd0);
    check("t5_sig_valid", {31'd0, sig_valid}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready},  32'd0);

    // Start pulse during RUN is ignored
    out_ready = 1'b1;
    do_start(16'd3);
    send(24'h000001);
    do_start(16'd1);
    check("t6_cnt_kept", {16'd0, vec_count}, 32'd1);
    check("t6_busy",     {31'd0, busy},      32'd1);
    send(24'h000002);
    check("t6_still_run", {31'd0, in_ready}, 32'd1);
    send(24'h000004);
    wait_done();
    check("t6_cnt", {16'd0, vec_count}, 32'd3);
    check("t6_sig", {8'd0, signature},  32'h000004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pla_resp_capture.md
Name: pla_resp_capture

Overview:
- Sits directly downstream of a generated combinational PLA block and consumes its 24-bit response vector, z00..z23 packed with z00 at bit 0.
- Buffers responses in a small FIFO and forwards them over a valid/ready interface to the downstream comparator.
- Compresses every accepted response into a MISR signature over a programmed number of vectors, so the PLA can be checked against a golden signature.

Parameters:
- OUT_W, 24, response vector width (PLA output count).
- FIFO_DEPTH, 4, number of buffer entries; power of two, at least 2.
- CNT_W, 16, width of the vector counter and of num_vec.
- MISR_POLY, 24'h00001B, MISR feedback polynomial, XORed in when the shifted-out MSB is 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a capture run; honoured only in IDLE or DONE.
- num_vec  input  CNT_W  number of vectors in the run; sampled on the accepted start.
- in_valid  input  1  upstream response valid.
- in_ready  output  1  block can accept a response.
- in_data  input  OUT_W  PLA response vector.
- out_valid  output  1  FIFO head valid toward downstream.
- out_ready  input  1  downstream accepts the head.
- out_data  output  OUT_W  FIFO head data.
- signature  output  OUT_W  current MISR value.
- sig_valid  output  1  final signature is ready; high only in DONE.
- vec_count  output  CNT_W  responses accepted in the current run.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset: state=IDLE, FIFO empty, pointers 0, signature=0, vec_count=0. in_ready, out_valid, sig_valid and busy are 0. out_data=0.
- States are IDLE, RUN, DRAIN and DONE.
- Accepted start (in IDLE or DONE):
  - latches num_vec into target;
  - clears signature and vec_count to 0;
  - if num_vec==0, goes directly to DONE with signature 0;
  - otherwise goes to RUN.
- A start pulse in RUN or DRAIN is ignored.
- in_ready = (state==RUN) & !fifo_full.
  - Full is evaluated before the same-cycle pop, so there is no push-through-on-pop when full.
- Input beat = in_valid & in_ready. On a beat:
  - in_data is pushed to the FIFO;
  - vec_count increments;
  - signature <= {signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ in_data.
- RUN to DRAIN on the beat that makes vec_count equal target. in_ready drops the next cycle, and further upstream data is not consumed.
- DRAIN to DONE in the first cycle the FIFO is empty (after the last pop).
- DONE: sig_valid=1 and signature held stable until the next accepted start or reset.
- Output beat = out_valid & out_ready. out_valid = !fifo_empty in any state. out_data is the registered FIFO head with no bubble, so FIFO latency is 1 cycle from push to out_valid.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- The FIFO is never flushed by start. Data in the FIFO always stems from a completed or current run.
- Pointer wrap uses a modulo FIFO_DEPTH index plus an extra wrap bit for the full/empty distinction.
- vec_count does not wrap within a run, because the run ends at target ≤ 2^CNT_W-1.
- A reset asserted mid-run discards FIFO contents, signature and count immediately on that edge.
- out_valid must not drop without an output beat. out_data must be stable while out_valid & !out_ready.

Test Plan:
- Reset, then start with num_vec=2; send 24'h000001 then 24'h000002 back-to-back with out_ready=1 -> out_data shows 000001 then 000002; signature goes 000001 then 000000; sig_valid rises after the drain; vec_count=2.
- Start with num_vec=1 and send 24'h800000, then start again with num_vec=1 and send 24'h000000 -> first run signature=800000; second run signature=000000 (it restarts from 0). Also preload signature=800000 via a 2-vector run of 800000 then 000000 -> signature=00001B.
- Hold out_ready=0 with num_vec=6 and stream continuously -> in_ready drops after 4 beats; release out_ready -> remaining 2 vectors accepted, order preserved, and no vector lost or duplicated.
- Start with num_vec=0 -> DONE the next cycle; sig_valid=1; signature=0; in_ready never asserts.
- Assert rst mid-run with 3 entries buffered -> the next cycle out_valid=0, busy=0, signature=0, vec_count=0, state IDLE.
- Start pulse during RUN -> ignored; vec_count continues and target is unchanged.
